// File: rtl/phy_tx_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_pkg
// Shared definitions for the USB full-speed transmit PHY. The line-state
// encodings are common with phy_rx so both directions agree on J/K/SE0.
// Contents:
//   SE0/DJ/DK/SE1  - 2-bit line states, bit0 = dp, bit1 = dn
//   SYNC_PATTERN   - SYNC byte, sent LSB first (KJKJKJKK)
//   STUFF_LIMIT    - number of consecutive 1s that forces a stuffed 0
//   nrzi_toggle()  - flips the line between J and K
// -----------------------------------------------------------------------------
package phy_tx_pkg;

    localparam logic [1:0] SE0 = 2'd0;
    localparam logic [1:0] DJ  = 2'd1;
    localparam logic [1:0] DK  = 2'd2;
    localparam logic [1:0] SE1 = 2'd3;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;

    // NRZI "0": the line changes state. Only ever applied to J or K.
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == DK) ? DJ : DK;
    endfunction

endpackage

// File: rtl/phy_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// phy_tx_bit_timer
// Free-running divider that marks the last clk_i cycle of every USB bit.
// Parameters:
//   BIT_SAMPLES - clk_i cycles per USB bit (>= 2)
// Ports:
//   clk_i     - clock, 12 MHz x BIT_SAMPLES
//   rstn_i    - asynchronous reset, active-low
//   bit_stb_o - high for one clk_i cycle when the count is BIT_SAMPLES-1
// -----------------------------------------------------------------------------
module phy_tx_bit_timer #(
    parameter int BIT_SAMPLES = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    output logic bit_stb_o
);

    localparam int CNT_W = (BIT_SAMPLES > 2) ? $clog2(BIT_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_stb_o = (cnt_q == CNT_LAST);
    assign cnt_d     = bit_stb_o ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phy_tx.sv
// -----------------------------------------------------------------------------
// phy_tx
// USB 2.0 full-speed transmit PHY. Serialises bytes from the SIE LSB first,
// prefixes SYNC, applies bit stuffing and NRZI, and closes with EOP.
// Optional feature macro: PHY_TX_ABORT_EN (adds tx_abort_i and the abort
// sequence: 8 bit times without transitions, then EOP).
// Parameters:
//   BIT_SAMPLES - clk_i cycles per USB bit (>= 2)
// Ports:
//   clk_i       - clock, 12 MHz x BIT_SAMPLES
//   rstn_i      - asynchronous reset, active-low
//   tx_data_i   - byte to send, taken when tx_ready_o and tx_valid_i are high
//   tx_valid_i  - SIE has a byte; low at a byte boundary ends the packet
//   tx_abort_i  - (PHY_TX_ABORT_EN only) abandon the packet
//   tx_ready_o  - one-clock pulse at each byte boundary
//   tx_en_o     - line drivers enabled, SYNC through the final J of EOP
//   tx_dp_o     - D+ line level
//   tx_dn_o     - D- line level
// -----------------------------------------------------------------------------
module phy_tx
    import phy_tx_pkg::*;
#(
    parameter int BIT_SAMPLES = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
`ifdef PHY_TX_ABORT_EN
    input  logic       tx_abort_i,
`endif
    output logic       tx_ready_o,
    output logic       tx_en_o,
    output logic       tx_dp_o,
    output logic       tx_dn_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
`ifdef PHY_TX_ABORT_EN
        ST_ABORT = 3'd4,
`endif
        ST_EOP   = 3'd3
    } state_t;

    logic       bit_stb;

    state_t     state_q,     state_d;
    logic [1:0] line_q,      line_d;
    logic       en_q,        en_d;
    logic [7:0] shift_q,     shift_d;
    logic [3:0] bit_cnt_q,   bit_cnt_d;    // bits of the current byte already on the line
    logic [2:0] stuff_cnt_q, stuff_cnt_d;  // consecutive 1s on the line
    logic [2:0] aux_cnt_q,   aux_cnt_d;    // EOP / abort bit-time counter

    logic       send_en;
    logic       send_bit;
    logic       start_sync;

    phy_tx_bit_timer #(
        .BIT_SAMPLES (BIT_SAMPLES)
    ) u_bit_timer (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .bit_stb_o (bit_stb)
    );

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        en_d        = en_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stuff_cnt_d = stuff_cnt_q;
        aux_cnt_d   = aux_cnt_q;
        tx_ready_o  = 1'b0;
        send_en     = 1'b0;
        send_bit    = 1'b0;
        start_sync  = 1'b0;

        if (bit_stb) begin
            case (state_q)
                ST_IDLE: begin
                    line_d = DJ;
                    en_d   = 1'b0;
                    if (tx_valid_i) begin
                        start_sync = 1'b1;
                    end
                end

                ST_SYNC, ST_DATA: begin
`ifdef PHY_TX_ABORT_EN
                    if (tx_abort_i) begin
                        // Line holds from this bit time on; counted in ST_ABORT.
                        state_d   = ST_ABORT;
                        aux_cnt_d = 3'd0;
                    end else
`endif
                    if (stuff_cnt_q == STUFF_LIMIT) begin
                        // Stuffed 0 takes a bit time but no data bit.
                        line_d      = nrzi_toggle(line_q);
                        stuff_cnt_d = 3'd0;
                    end else if (bit_cnt_q != 4'd8) begin
                        send_en   = 1'b1;
                        send_bit  = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        // Byte boundary: the first bit of the next byte goes out
                        // on this same strobe so bytes follow without a gap.
                        tx_ready_o = 1'b1;
                        if (tx_valid_i) begin
                            state_d   = ST_DATA;
                            send_en   = 1'b1;
                            send_bit  = tx_data_i[0];
                            shift_d   = {1'b0, tx_data_i[7:1]};
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d     = ST_EOP;
                            line_d      = SE0;
                            aux_cnt_d   = 3'd0;
                            stuff_cnt_d = 3'd0;
                        end
                    end
                end

                ST_EOP: begin
                    if (aux_cnt_q == 3'd0) begin
                        line_d    = SE0;
                        aux_cnt_d = 3'd1;
                    end else if (aux_cnt_q == 3'd1) begin
                        line_d    = DJ;
                        aux_cnt_d = 3'd2;
                    end else begin
                        state_d   = ST_IDLE;
                        en_d      = 1'b0;
                        aux_cnt_d = 3'd0;
                        // A following packet may begin right after the J of EOP.
                        if (tx_valid_i) begin
                            start_sync = 1'b1;
                        end
                    end
                end

`ifdef PHY_TX_ABORT_EN
                ST_ABORT: begin
                    if (aux_cnt_q == 3'd7) begin
                        state_d     = ST_EOP;
                        line_d      = SE0;
                        aux_cnt_d   = 3'd0;
                        stuff_cnt_d = 3'd0;
                    end else begin
                        aux_cnt_d = aux_cnt_q + 3'd1;
                    end
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                    line_d  = DJ;
                    en_d    = 1'b0;
                end
            endcase

            if (start_sync) begin
                state_d   = ST_SYNC;
                en_d      = 1'b1;
                send_en   = 1'b1;
                send_bit  = SYNC_PATTERN[0];
                shift_d   = {1'b0, SYNC_PATTERN[7:1]};
                bit_cnt_d = 4'd1;
            end

            // NRZI: 1 holds the line and extends the run of 1s, 0 toggles.
            if (send_en) begin
                if (send_bit) begin
                    stuff_cnt_d = stuff_cnt_q + 3'd1;
                end else begin
                    line_d      = nrzi_toggle(line_q);
                    stuff_cnt_d = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            line_q      <= DJ;
            en_q        <= 1'b0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            stuff_cnt_q <= 3'd0;
            aux_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            en_q        <= en_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stuff_cnt_q <= stuff_cnt_d;
            aux_cnt_q   <= aux_cnt_d;
        end
    end

    assign tx_dp_o = line_q[0];
    assign tx_dn_o = line_q[1];
    assign tx_en_o = en_q;

endmodule
